ps2_scancode_decoder: RTL
=========================

Name: ps2_scancode_decoder

Overview:
Consumes raw 8-bit PS/2 Set-2 scan code bytes from the keyboard receive stage and assembles them into complete key events. Handles the E0 (extended) and F0 (break) prefixes and the E1 Pause sequence. Tracks modifier state and queues events in a small FIFO with a valid/ready handshake toward the downstream key consumer.

Parameters:
FIFO_DEPTH, 4, number of queued key events; power of two, >= 2
TIMEOUT_CYCLES, 1000000, clk cycles a partial sequence may sit idle before the decoder abandons it (20 ms at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
code_valid  in  1  one-cycle strobe: code holds a new received byte (clk domain)
code  in  8  received scan code byte
evt_valid  out  1  FIFO head holds a valid event
evt_ready  in  1  consumer accepts head when evt_valid && evt_ready
evt_code  out  8  base scan code of head event
evt_ext  out  1  head event was E0-prefixed
evt_release  out  1  head event is a break (key up)
overflow  out  1  sticky: an event was dropped because the FIFO was full
shift_held  out  1  L-shift (12) or R-shift (59) currently down
ctrl_held  out  1  L-ctrl (14) or R-ctrl (E0 14) down
alt_held  out  1  L-alt (11) or R-alt (E0 11) down
caps_lock  out  1  caps-lock toggle state

Behaviour:
- One clock, one synchronous active-high reset. Every port and internal register is sampled/updated on rising clk.
- Reset: FSM to IDLE; FIFO empty; evt_valid=0; evt_code=0, evt_ext=0, evt_release=0; overflow=0; all modifier outputs 0; timeout counter 0.
- Reset asserted mid-sequence or mid-handshake discards the partial sequence and all queued events. No event is emitted for discarded data.
- Bytes are processed only on cycles where code_valid=1.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (skipping).
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE with skip count 7.
  - Bytes 00, AA, EE, FA, FC, FE and FF are ignored; stay in IDLE.
  - Any other byte pushes {ext=0, rel=0, code} and stays in IDLE.
- EXT transitions:
  - F0 -> EXT_BRK.
  - 12 or 59 (fake shift) is dropped -> IDLE.
  - Any other byte pushes {1, 0, code} -> IDLE.
- BRK: any byte pushes {0, 1, code} -> IDLE.
- EXT_BRK: 12 or 59 is dropped -> IDLE; any other byte pushes {1, 1, code} -> IDLE.
- PAUSE:
  - Each byte decrements the skip count.
  - When the count reaches 0, push a single {ext=1, rel=0, code=77} -> IDLE.
  - No break event is produced for Pause.
- Timeout:
  - The counter runs only in EXT, BRK, EXT_BRK and PAUSE, and clears on every code_valid.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE with no push and the counter clears.
- Modifiers update on the same edge as the corresponding push, and also update when that push is dropped for overflow.
  - shift, ctrl and alt are set by make events and cleared by break events of their listed codes.
  - caps_lock toggles on a make of 58 only if 58 is not already tracked as held. Typematic repeats do not toggle it.
  - A break of 58 clears the held tracking for 58.
- FIFO:
  - Each entry is 10 bits {ext, rel, code}.
  - Latency: an event-completing byte strobed in cycle N produces evt_valid=1 in cycle N+1 when the FIFO was empty.
  - Outputs are driven from the head entry and are stable while evt_valid && !evt_ready.
  - Pop occurs when evt_valid && evt_ready.
  - Push when full without a pop in the same cycle: the event is dropped, overflow is set, and FIFO contents are unchanged.
  - Push when full with a pop in the same cycle: both occur, nothing is lost, overflow is unchanged.
  - Push when empty with evt_ready=1: the event is still registered first and is popped no earlier than cycle N+1.
  - Read and write pointers wrap modulo FIFO_DEPTH. The occupancy counter ranges 0..FIFO_DEPTH.
- overflow clears only on reset.

Test Plan:
- Reset then bytes 1C; F0 1C, consumer ready -> events {0,0,1C} then {0,1,1C}; evt_valid rises in the cycle after the 1C strobe.
- Bytes E0 75; E0 F0 75 -> {1,0,75}, {1,1,75}; bytes E0 12 E0 7C -> only {1,0,7C}; ignored bytes AA, FA -> no event.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one {1,0,77}; FSM back in IDLE.
- evt_ready=0, push 5 makes with FIFO_DEPTH=4 -> 4 queued, 5th dropped, overflow=1. Separately, push while full with simultaneous pop -> no loss, overflow stays 0.
- Make 12 -> shift_held=1; break 12 -> 0. Make 58 three times, then break 58, then make 58 -> caps_lock 0->1 on the first make, stays 1 through the repeats, then ->0 on the final make.
- E0 alone followed by TIMEOUT_CYCLES idle cycles, then 1C -> {0,0,1C}, not an extended event. Reset asserted between F0 and 1C -> no event, FIFO empty, modifiers 0.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code decoder.
// Turns the raw byte stream from the keyboard receiver into complete key
// events (make/break, extended), skips the Pause sequence, tracks modifier
// keys and caps lock, and queues events for a valid/ready consumer.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       overflow,
    output logic       shift_held,
    output logic       ctrl_held,
    output logic       alt_held,
    output logic       caps_lock
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } state_t;

    state_t            state_q;
    logic [2:0]        skip_q;
    logic [TO_W-1:0]   tmo_q;

    logic              push_d;
    logic [9:0]        entry_d;
    logic              isIgnored;
    logic              isFakeShift;

    logic [9:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q;
    logic [PTR_W-1:0]  rd_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              pop;
    logic              push_ok;

    logic              shift_q;
    logic              ctrl_q;
    logic              alt_q;
    logic              caps_q;
    logic              caps_held_q;

    // Decode the incoming byte in the current state into a possible event push.
    always_comb begin
        push_d      = 1'b0;
        entry_d     = {2'b00, code};
        isIgnored   = (code == 8'h00) || (code == 8'hAA) || (code == 8'hEE) ||
                      (code == 8'hFA) || (code == 8'hFC) || (code == 8'hFE) ||
                      (code == 8'hFF);
        isFakeShift = (code == 8'h12) || (code == 8'h59);
        if (code_valid) begin
            case (state_q)
                IDLE: begin
                    if (code != 8'hE0 && code != 8'hF0 && code != 8'hE1 && !isIgnored) begin
                        push_d  = 1'b1;
                        entry_d = {2'b00, code};
                    end
                end
                EXT: begin
                    if (code != 8'hF0 && !isFakeShift) begin
                        push_d  = 1'b1;
                        entry_d = {2'b10, code};
                    end
                end
                BRK: begin
                    push_d  = 1'b1;
                    entry_d = {2'b01, code};
                end
                EXT_BRK: begin
                    if (!isFakeShift) begin
                        push_d  = 1'b1;
                        entry_d = {2'b11, code};
                    end
                end
                PAUSE: begin
                    if (skip_q <= 3'd1) begin
                        push_d  = 1'b1;
                        entry_d = {2'b10, 8'h77};
                    end
                end
                default: begin
                    push_d = 1'b0;
                end
            endcase
        end
    end

    // Prefix-tracking state machine with the idle timeout that abandons
    // partial sequences; a received byte always takes priority over timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            skip_q  <= 3'd0;
            tmo_q   <= '0;
        end else if (code_valid) begin
            tmo_q <= '0;
            case (state_q)
                IDLE: begin
                    if (code == 8'hE0) begin
                        state_q <= EXT;
                    end else if (code == 8'hF0) begin
                        state_q <= BRK;
                    end else if (code == 8'hE1) begin
                        state_q <= PAUSE;
                        skip_q  <= 3'd7;
                    end
                end
                EXT: begin
                    state_q <= (code == 8'hF0) ? EXT_BRK : IDLE;
                end
                BRK, EXT_BRK: begin
                    state_q <= IDLE;
                end
                PAUSE: begin
                    if (skip_q <= 3'd1) begin
                        state_q <= IDLE;
                        skip_q  <= 3'd0;
                    end else begin
                        skip_q <= skip_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TO_LAST) begin
                state_q <= IDLE;
                tmo_q   <= '0;
            end else begin
                tmo_q <= tmo_q + TO_W'(1);
            end
        end
    end

    // Modifier tracking follows every decoded event, even one the FIFO drops,
    // so key state never drifts from the keyboard when the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= 1'b0;
            ctrl_q      <= 1'b0;
            alt_q       <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
        end else if (push_d) begin
            if (!entry_d[9] && (entry_d[7:0] == 8'h12 || entry_d[7:0] == 8'h59)) begin
                shift_q <= !entry_d[8];
            end
            if (entry_d[7:0] == 8'h14) begin
                ctrl_q <= !entry_d[8];
            end
            if (entry_d[7:0] == 8'h11) begin
                alt_q <= !entry_d[8];
            end
            if (!entry_d[9] && entry_d[7:0] == 8'h58) begin
                if (entry_d[8]) begin
                    caps_held_q <= 1'b0;
                end else if (!caps_held_q) begin
                    caps_held_q <= 1'b1;
                    caps_q      <= !caps_q;
                end
            end
        end
    end

    assign pop     = (count_q != '0) && evt_ready;
    assign push_ok = push_d && ((count_q != FULL_COUNT) || pop);

    // Event FIFO: a push into a full queue is lost unless a pop frees a slot
    // on the same edge; the sticky overflow flag records any loss.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= entry_d;
                wr_q        <= wr_q + PTR_W'(1);
            end else if (push_d) begin
                overflow_q <= 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_ok && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Present the head entry, forcing zeros whenever the queue is empty.
    always_comb begin
        evt_valid   = (count_q != '0);
        evt_code    = 8'h00;
        evt_ext     = 1'b0;
        evt_release = 1'b0;
        if (evt_valid) begin
            {evt_ext, evt_release, evt_code} = mem_q[rd_q];
        end
    end

    assign overflow   = overflow_q;
    assign shift_held = shift_q;
    assign ctrl_held  = ctrl_q;
    assign alt_held   = alt_q;
    assign caps_lock  = caps_q;

endmodule
